// File: rtl/shared_mem_arb_pkg.sv
// Shared types and helpers for the shared-memory round-robin arbiter.
package shared_mem_arb_pkg;

    // Widest master id the read pipeline must carry (up to 8 masters)
    localparam int unsigned MAX_ID_W = 3;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // One read-return pipeline stage: who issued the read, and whether it is live
    typedef struct packed {
        logic                valid;
        logic [MAX_ID_W-1:0] id;
    } rd_entry_t;

    // Master id width: clog2(n), never less than one bit
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first requester at or after pointer, circular.
module rr_grant #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] pointer,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] id,
    output logic            any
);

    logic [ID_W-1:0] idx;

    // Scan masters starting from pointer and take the first one requesting
    always_comb begin
        grant = '0;
        id    = '0;
        any   = 1'b0;
        idx   = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = ID_W'((32'(pointer) + k) % N);
            if (!any && req[idx]) begin
                grant[idx] = 1'b1;
                id         = idx;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Round-robin Avalon-MM arbiter sharing one single-port RAM among several masters,
// with a bounded lock for atomic read-modify-write sequences.
module shared_mem_arbiter
    import shared_mem_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 4,
    parameter int unsigned ADDR_W       = 13,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned BE_W         = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned MAX_LOCK     = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
    input  logic [NUM_MASTERS-1:0]        m_read,
    input  logic [NUM_MASTERS-1:0]        m_write,
    input  logic [NUM_MASTERS-1:0]        m_lock,
    input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
    output logic [NUM_MASTERS-1:0]        m_waitrequest,
    output logic [DATA_W-1:0]             m_readdata,
    output logic [NUM_MASTERS-1:0]        m_readdatavalid,
    output logic [ADDR_W-1:0]             mem_address,
    output logic [BE_W-1:0]               mem_byteenable,
    output logic                          mem_chipselect,
    output logic                          mem_write,
    output logic [DATA_W-1:0]             mem_writedata,
    output logic                          mem_clken,
    input  logic [DATA_W-1:0]             mem_readdata
);

    localparam int unsigned ID_W  = id_width(NUM_MASTERS);
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t       state;
    logic [ID_W-1:0]  pointer;
    logic [ID_W-1:0]  owner;
    logic [CNT_W-1:0] lock_cnt;
    rd_entry_t        pipe [READ_LATENCY];

    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] rr_gnt;
    logic [NUM_MASTERS-1:0] grant;
    logic [ID_W-1:0]        rr_id;
    logic [ID_W-1:0]        gid;
    logic                   rr_any;
    logic                   accept;
    logic                   release_lock;
    logic                   rd_accept;

    assign req = m_read | m_write;

    rr_grant #(
        .N    (NUM_MASTERS),
        .ID_W (ID_W)
    ) u_rr_grant (
        .req     (req),
        .pointer (pointer),
        .grant   (rr_gnt),
        .id      (rr_id),
        .any     (rr_any)
    );

    // Circular successor of a master id
    function automatic logic [ID_W-1:0] next_ptr(input logic [ID_W-1:0] g);
        return (32'(g) == NUM_MASTERS - 1) ? ID_W'(0) : g + ID_W'(1);
    endfunction

    // Grant decision: round-robin when free, owner-only while locked
    always_comb begin
        grant        = '0;
        gid          = '0;
        accept       = 1'b0;
        release_lock = 1'b0;
        if (state == ARB) begin
            grant  = rr_gnt;
            gid    = rr_id;
            accept = rr_any;
        end else if (lock_cnt == CNT_W'(MAX_LOCK) || !req[owner]) begin
            // Lock expired or owner went quiet: spend this cycle releasing
            release_lock = 1'b1;
        end else begin
            grant        = NUM_MASTERS'(1) << owner;
            gid          = owner;
            accept       = 1'b1;
            release_lock = !m_lock[owner];
        end
        if (!reset_n) begin
            grant  = '0;
            accept = 1'b0;
        end
    end

    // A write beats a simultaneous read; only pure reads produce return data
    assign rd_accept = accept & m_read[gid] & ~m_write[gid];

    assign m_waitrequest  = reset_n ? (req & ~grant) : '1;
    assign mem_chipselect = accept;
    assign mem_write      = accept & m_write[gid];
    assign mem_address    = m_address[32'(gid)*ADDR_W +: ADDR_W];
    assign mem_byteenable = m_byteenable[32'(gid)*BE_W +: BE_W];
    assign mem_writedata  = m_writedata[32'(gid)*DATA_W +: DATA_W];
    assign mem_clken      = 1'b1;

    assign m_readdata      = mem_readdata;
    assign m_readdatavalid = (reset_n && pipe[READ_LATENCY-1].valid)
                             ? NUM_MASTERS'(1) << pipe[READ_LATENCY-1].id : '0;

    // Read-return pipeline tracking which master each in-flight read belongs to
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: rd_accept, id: MAX_ID_W'(gid)};
            for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    // Arbitration state, round-robin pointer and lock bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ARB;
            pointer  <= '0;
            owner    <= '0;
            lock_cnt <= '0;
        end else begin
            case (state)
                ARB: begin
                    if (accept) begin
                        pointer <= next_ptr(gid);
                        if (m_lock[gid]) begin
                            state    <= LOCKED;
                            owner    <= gid;
                            lock_cnt <= CNT_W'(1);
                        end
                    end
                end
                LOCKED: begin
                    if (release_lock) begin
                        state    <= ARB;
                        pointer  <= next_ptr(owner);
                        lock_cnt <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + CNT_W'(1);
                    end
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// Self-checking bench for shared_mem_arbiter: directed scenarios plus random traffic
// checked every cycle against a behavioural model of arbitration, memory and returns.
module tb_shared_mem_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;
    localparam int unsigned RL = 1;
    localparam int          ML = 16;

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N*AW-1:0]   m_address;
    logic [N-1:0]      m_read;
    logic [N-1:0]      m_write;
    logic [N-1:0]      m_lock;
    logic [N*BW-1:0]   m_byteenable;
    logic [N*DW-1:0]   m_writedata;
    logic [N-1:0]      m_waitrequest;
    logic [DW-1:0]     m_readdata;
    logic [N-1:0]      m_readdatavalid;
    logic [AW-1:0]     mem_address;
    logic [BW-1:0]     mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DW-1:0]     mem_writedata;
    logic              mem_clken;
    logic [DW-1:0]     mem_readdata;

    shared_mem_arbiter #(
        .NUM_MASTERS  (N),
        .ADDR_W       (AW),
        .DATA_W       (DW),
        .BE_W         (BW),
        .READ_LATENCY (RL),
        .MAX_LOCK     (ML)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .m_address       (m_address),
        .m_read          (m_read),
        .m_write         (m_write),
        .m_lock          (m_lock),
        .m_byteenable    (m_byteenable),
        .m_writedata     (m_writedata),
        .m_waitrequest   (m_waitrequest),
        .m_readdata      (m_readdata),
        .m_readdatavalid (m_readdatavalid),
        .mem_address     (mem_address),
        .mem_byteenable  (mem_byteenable),
        .mem_chipselect  (mem_chipselect),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_clken       (mem_clken),
        .mem_readdata    (mem_readdata)
    );

    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // RAM attached to the s1 side: one-cycle registered read, byte-enabled write
    logic [31:0] ram [8192] = '{default: 32'h0};
    logic [31:0] ram_w;
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (mem_write) begin
                ram_w = ram[mem_address];
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b]) ram_w[b*8 +: 8] = mem_writedata[b*8 +: 8];
                ram[mem_address] <= ram_w;
            end
            mem_readdata <= ram[mem_address];
        end
    end

    // Behavioural model state
    typedef struct {
        int          id;
        logic [31:0] data;
        int          due;
    } ret_t;

    logic [31:0] ref_mem [8192] = '{default: 32'h0};
    ret_t        rq [$];
    int          ptr_m   = 0;
    int          owner_m = -1;
    int          held_m  = 0;
    logic [N-1:0] acc_m  = '0;

    // Compare DUT against the model every cycle, then advance the model past the edge
    always @(negedge clk) begin
        logic [N-1:0] req_m, exp_wait, exp_rdv;
        logic [31:0]  exp_data, word;
        logic [AW-1:0] a;
        int g;
        chk("mem_clken", 64'(mem_clken), 64'd1);
        if (!reset_n) begin
            chk("rst_waitrequest", 64'(m_waitrequest), 64'hF);
            chk("rst_chipselect", 64'(mem_chipselect), 64'd0);
            chk("rst_mem_write", 64'(mem_write), 64'd0);
            chk("rst_readdatavalid", 64'(m_readdatavalid), 64'd0);
            rq.delete();
            ptr_m   = 0;
            owner_m = -1;
            held_m  = 0;
            acc_m   = '0;
        end else begin
            req_m = m_read | m_write;
            g = -1;
            if (owner_m < 0) begin
                for (int k = 0; k < N; k++)
                    if (g < 0 && req_m[(ptr_m + k) % N]) g = (ptr_m + k) % N;
            end else if (held_m < ML && req_m[owner_m]) begin
                g = owner_m;
            end
            exp_wait = req_m & ~((g >= 0) ? (N'(1) << g) : N'(0));
            chk("waitrequest", 64'(m_waitrequest), 64'(exp_wait));
            chk("chipselect", 64'(mem_chipselect), 64'(g >= 0));
            chk("mem_write", 64'(mem_write), 64'(g >= 0 && m_write[g]));
            if (g >= 0) begin
                a = m_address[g*AW +: AW];
                chk("mem_address", 64'(mem_address), 64'(a));
                chk("mem_byteenable", 64'(mem_byteenable), 64'(m_byteenable[g*BW +: BW]));
                chk("mem_writedata", 64'(mem_writedata), 64'(m_writedata[g*DW +: DW]));
            end
            exp_rdv  = '0;
            exp_data = '0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                exp_rdv  = N'(1) << rq[0].id;
                exp_data = rq[0].data;
                void'(rq.pop_front());
            end
            chk("readdatavalid", 64'(m_readdatavalid), 64'(exp_rdv));
            if (exp_rdv != '0) chk("readdata", 64'(m_readdata), 64'(exp_data));

            acc_m = '0;
            if (g >= 0) begin
                acc_m[g] = 1'b1;
                a = m_address[g*AW +: AW];
                if (m_write[g]) begin
                    word = ref_mem[a];
                    for (int b = 0; b < 4; b++)
                        if (m_byteenable[g*BW + b]) word[b*8 +: 8] = m_writedata[g*DW + b*8 +: 8];
                    ref_mem[a] = word;
                end else if (m_read[g]) begin
                    rq.push_back('{g, ref_mem[a], cyc + int'(RL)});
                end
            end
            if (owner_m < 0) begin
                if (g >= 0) begin
                    ptr_m = (g + 1) % N;
                    if (m_lock[g]) begin
                        owner_m = g;
                        held_m  = 1;
                    end
                end
            end else if (g < 0 || !m_lock[owner_m]) begin
                ptr_m   = (owner_m + 1) % N;
                owner_m = -1;
                held_m  = 0;
            end else begin
                held_m++;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        m_read  = '0;
        m_write = '0;
        m_lock  = '0;
    endtask

    task automatic drive(input int i, input logic r, input logic w, input logic l,
                         input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [DW-1:0] d);
        m_read[i]                = r;
        m_write[i]               = w;
        m_lock[i]                = l;
        m_address[i*AW +: AW]    = a;
        m_byteenable[i*BW +: BW] = b;
        m_writedata[i*DW +: DW]  = d;
    endtask

    task automatic pulse_reset();
        idle_all();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        logic [3:0] e;
        int acc_cnt;
        int x;
        reset_n      = 1'b0;
        m_address    = '0;
        m_byteenable = '0;
        m_writedata  = '0;
        idle_all();
        repeat (3) tick();
        reset_n = 1'b1;

        // Single master write then read-back
        drive(0, 1'b0, 1'b1, 1'b0, 13'h005, 4'hF, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_write_wait", 64'(m_waitrequest), 64'h0);
        chk("t1_write_strobe", 64'(mem_write), 64'd1);
        tick();
        drive(0, 1'b1, 1'b0, 1'b0, 13'h005, 4'hF, 32'h0);
        @(negedge clk);
        chk("t1_read_wait", 64'(m_waitrequest), 64'h0);
        tick();
        idle_all();
        @(negedge clk);
        chk("t1_rdv", 64'(m_readdatavalid), 64'h1);
        chk("t1_data", 64'(m_readdata), 64'hDEADBEEF);
        tick();

        // All four masters reading every cycle rotate 0,1,2,3,0
        pulse_reset();
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 1'b0, AW'(13'h100 + i), 4'hF, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            e = 4'hF & ~(4'b0001 << (k % 4));
            chk("t2_wait", 64'(m_waitrequest), 64'(e));
            if (k > 0) begin
                e = 4'b0001 << ((k - 1) % 4);
                chk("t2_rdv", 64'(m_readdatavalid), 64'(e));
            end
            tick();
        end
        idle_all();
        @(negedge clk);
        chk("t2_rdv_last", 64'(m_readdatavalid), 64'h1);
        tick();

        // Partial byte-enable write over zero
        drive(2, 1'b0, 1'b1, 1'b0, 13'h1FFF, 4'b0101, 32'h11223344);
        tick();
        drive(2, 1'b1, 1'b0, 1'b0, 13'h1FFF, 4'hF, 32'h0);
        tick();
        idle_all();
        @(negedge clk);
        chk("t3_rdv", 64'(m_readdatavalid), 64'h4);
        chk("t3_data", 64'(m_readdata), 64'h00220044);
        tick();

        // Locked 3-transaction RMW by m1 while m2 waits
        pulse_reset();
        drive(1, 1'b1, 1'b0, 1'b1, 13'h020, 4'hF, 32'h0);
        drive(2, 1'b0, 1'b1, 1'b0, 13'h030, 4'hF, 32'hCAFE0002);
        @(negedge clk); chk("t4_lock_a", 64'(m_waitrequest), 64'h4); tick();
        drive(1, 1'b1, 1'b0, 1'b1, 13'h021, 4'hF, 32'h0);
        @(negedge clk); chk("t4_lock_b", 64'(m_waitrequest), 64'h4); tick();
        drive(1, 1'b0, 1'b1, 1'b0, 13'h020, 4'hF, 32'h12345678);
        @(negedge clk); chk("t4_lock_c", 64'(m_waitrequest), 64'h4); tick();
        drive(0, 1'b1, 1'b0, 1'b0, 13'h040, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 13'h041, 4'hF, 32'h0);
        @(negedge clk); chk("t4_after_release", 64'(m_waitrequest), 64'h3); tick();
        m_write[2] = 1'b0;
        @(negedge clk); chk("t4_next_m0", 64'(m_waitrequest), 64'h2); tick();
        m_read[0] = 1'b0;
        @(negedge clk); chk("t4_next_m1", 64'(m_waitrequest), 64'h0); tick();
        idle_all();
        tick();

        // Lock timeout: m0 locked continuously, m3 waiting
        pulse_reset();
        acc_cnt = 0;
        drive(3, 1'b1, 1'b0, 1'b0, 13'h060, 4'hF, 32'h0);
        for (int k = 0; k < 18; k++) begin
            drive(0, 1'b1, 1'b0, 1'b1, AW'(13'h050 + k), 4'hF, 32'h0);
            @(negedge clk);
            e = (k < 16) ? 4'b1000 : ((k == 16) ? 4'b1001 : 4'b0001);
            chk("t5_wait", 64'(m_waitrequest), 64'(e));
            if (k < 17 && !m_waitrequest[0]) acc_cnt++;
            tick();
        end
        chk("t5_accepts", 64'(acc_cnt), 64'd16);
        idle_all();
        tick();

        // Reset with a read in flight drops it and clears the pointer
        drive(1, 1'b1, 1'b0, 1'b0, 13'h005, 4'hF, 32'h0);
        @(negedge clk); chk("t6_issue", 64'(m_waitrequest), 64'h0); tick();
        idle_all();
        reset_n = 1'b0;
        @(negedge clk); chk("t6_rdv_in_reset", 64'(m_readdatavalid), 64'h0); tick();
        reset_n = 1'b1;
        @(negedge clk); chk("t6_rdv_after_reset", 64'(m_readdatavalid), 64'h0); tick();
        for (int i = 0; i < N; i++) drive(i, 1'b1, 1'b0, 1'b0, AW'(i), 4'hF, 32'h0);
        @(negedge clk); chk("t6_pointer_zero", 64'(m_waitrequest), 64'hE); tick();
        idle_all();
        tick();

        // Random traffic; stalled masters hold their request
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset();
                continue;
            end
            for (int i = 0; i < N; i++) begin
                if ((m_read[i] | m_write[i]) && !acc_m[i]) continue;
                x = int'($urandom_range(0, 9));
                if (x < 4) begin
                    drive(i, 1'b0, 1'b0, 1'b0, AW'(0), 4'h0, 32'h0);
                end else begin
                    drive(i, (x < 7) || (x == 9), (x >= 7), ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)),
                          BW'($urandom), $urandom);
                end
            end
            tick();
        end
        idle_all();
        repeat (4) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
